noc_rr_arbiter: RTL
===================

# noc_rr_arbiter

Parametrised output-port arbiter for the NoC router, successor to the fixed five-input L/N/E/W/S priority arbiter. It arbitrates `NPORTS` input channels onto one output using rotating round-robin priority instead of fixed per-state priority. A single shared hold counter, whose limit is latched per port from the header flit's length field, enforces a per-packet timeout. Grant is registered and one-hot and sits between the input buffers and the crossbar select.

## Interface
Parameters:
- `NPORTS`, 5, number of requesting channels (2..16)
- `LEN_W`, 12, width of per-port length / timeout limit
- `FID_W`, 3, width of per-port flit_id
- `HEADER_ID`, 1, flit_id value marking a header flit (latches the length)
- `IDX_W`, $clog2(NPORTS), width of the grant index

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  NPORTS  per-port request, bit i = port i
- `flit_id`  in  NPORTS*FID_W  per-port flit id, port i at [i*FID_W +: FID_W]
- `length`  in  NPORTS*LEN_W  per-port packet length, port i at [i*LEN_W +: LEN_W]
- `grant`  out  NPORTS  registered one-hot grant, all-zero when idle
- `grant_valid`  out  1  registered, equals |grant
- `grant_idx`  out  IDX_W  registered index of granted port, 0 when idle
- `timeout`  out  NPORTS  one-cycle pulse on port whose grant was revoked by timeout

## Operation
- State: IDLE (grant_valid=0) or HOLD (grant_valid=1, owner p = grant_idx).
- Limit registers `lim[i]`:
  - Every cycle, independent of grant, if flit_id[i]==HEADER_ID, then lim[i] <= length[i].
  - Otherwise lim[i] holds its value.
- Round-robin pointer `ptr`: after any grant to port p, ptr <= (p+1) mod NPORTS.
- Pick function: the first set bit of `req` scanning ptr, ptr+1, … wrapping mod NPORTS.
- IDLE:
  - If req != 0, enter HOLD with owner = pick, and cnt <= 0.
  - Otherwise stay in IDLE.
- HOLD, owner p:
  - keep: req[p]==1 and cnt != lim[p]. Stay with owner p; cnt <= cnt+1, saturating at 2^LEN_W-1.
  - release: req[p]==0, or cnt==lim[p].
    - Scan from ptr (=p+1) over req with bit p masked off.
    - If another port is found, switch directly to it with cnt <= 0 (no idle bubble).
    - Otherwise, if req[p]==1, regrant p with cnt <= 0.
    - Otherwise go to IDLE.
- timeout[p] pulses for the cycle after release when the release cause was cnt==lim[p] while req[p]==1. It pulses even if p is immediately regranted.
- Maximum hold per grant is lim[p]+1 cycles. lim==0 gives a one-cycle grant.
- The comparison uses the lim[p] value current in the evaluating cycle. A mid-packet header rewrite takes effect immediately.
- Reset values: grant=0, grant_valid=0, grant_idx=0, timeout=0, ptr=0, cnt=0, all lim=0.
- Reset mid-HOLD drops grant on the next edge with no timeout pulse.

## Timing
- Next-state and pick logic are combinational on registered state plus inputs. grant, grant_idx, grant_valid and timeout update on the next rising edge.
- Latency from req rising to grant is 1 cycle.
- Latency from req[p] falling to grant[p] clearing is 1 cycle.
- grant is never multi-hot. grant_idx and grant change in the same cycle.
- Simultaneous header latch and release evaluation: the compare uses the old lim; the new lim applies from the next cycle.
- rst has priority over all other inputs.

## Test plan
- Reset, then all req=0 -> grant=0, grant_valid=0, timeout=0 for 10 cycles.
- req=5'b00101, all lim=0, held continuously -> grants alternate one-hot 00001, 00100, 00001 … one cycle each. timeout pulses on the released port every cycle.
- Header with length=3 on port 1, req[1] held alone -> grant[1] for 4 cycles. timeout[1] pulses. Port 1 is regranted next cycle with cnt=0.
- Port 0 granted with lim=10, req[0] drops after 2 cycles while req[3]=1 -> grant switches 00001 to 01000 on the next edge with no idle cycle and no timeout pulse.
- All five ports request with lim=2 -> grant order 0,1,2,3,4,0, each held 3 cycles, 5 timeout pulses per rotation.
- rst asserted mid-HOLD -> next edge: grant=0, ptr=0. After rst drops with req=5'b11111 -> grant=00001.

Source files
------------

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter for the NoC router.
// It gives a registered one-hot grant and a per-packet hold timeout taken from the header length.
module noc_rr_arbiter #(
    parameter int NPORTS    = 5,
    parameter int LEN_W     = 12,
    parameter int FID_W     = 3,
    parameter int HEADER_ID = 1,
    parameter int IDX_W     = $clog2(NPORTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         req,
    input  logic [NPORTS*FID_W-1:0]   flit_id,
    input  logic [NPORTS*LEN_W-1:0]   length,
    output logic [NPORTS-1:0]         grant,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [NPORTS-1:0]         timeout,
    output logic                      dbg_state
);

    // Handshake: a port holds req high for as long as it wants the output.
    // grant[i] follows one cycle later and stays high until req[i] drops or the hold limit expires.
    // There is no ready signal: a grant implies the crossbar path is taken.

    localparam int JW = IDX_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
    logic [LEN_W-1:0]    r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0]    r_lim [NPORTS];
    logic [NPORTS-1:0]   r_grant, w_grant_nxt;
    logic [NPORTS-1:0]   r_timeout, w_timeout_nxt;
    logic                w_to_cause;

    logic [NPORTS-1:0]   w_scan_req;
    logic                w_pick_found;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_own_req;
    logic                w_lim_hit;

    // The owner is masked out of the scan, so a releasing port is regranted only when nobody else is waiting.
    always_comb begin
        logic [JW-1:0] v_j;
        w_scan_req   = (r_state == S_HOLD) ? (req & ~(NPORTS'(1) << r_idx)) : req;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        v_j          = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            v_j = {1'b0, r_ptr} + JW'(k);
            if (v_j >= JW'(NPORTS)) begin
                v_j = v_j - JW'(NPORTS);
            end
            if (w_scan_req[v_j]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = v_j[IDX_W-1:0];
            end
        end
    end

    assign w_own_req = req[r_idx];
    assign w_lim_hit = (r_cnt == r_lim[r_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_timeout <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Headers latch the limit on every cycle, whether or not the port is granted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (rst) begin
                r_lim[i] <= '0;
            end else if (flit_id[i*FID_W +: FID_W] == FID_W'(HEADER_ID)) begin
                r_lim[i] <= length[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_to_cause  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = S_HOLD;
                    w_idx_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            S_HOLD: begin
                if (w_own_req && !w_lim_hit) begin
                    w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                end else begin
                    w_to_cause = w_own_req;
                    if (w_pick_found) begin
                        w_idx_nxt = w_pick_idx;
                        w_cnt_nxt = '0;
                    end else if (w_own_req) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
        w_ptr_nxt = r_ptr;
        if (w_state_nxt == S_HOLD) begin
            w_ptr_nxt = (w_idx_nxt == IDX_W'(NPORTS - 1)) ? '0 : w_idx_nxt + 1'b1;
        end
    end

    always_comb begin
        w_grant_nxt   = '0;
        w_timeout_nxt = '0;
        if (w_state_nxt == S_HOLD) begin
            w_grant_nxt[w_idx_nxt] = 1'b1;
        end
        if (w_to_cause) begin
            w_timeout_nxt[r_idx] = 1'b1;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = (r_state == S_HOLD);
    assign grant_idx   = r_idx;
    assign timeout     = r_timeout;
    assign dbg_state   = r_state;

endmodule
